// File: rtl/cache_req_pkg.sv
// Shared types for the cache request queue: the stored cache command and
// the helper that turns an arbitrated word plus read/write tag into one.
package cache_req_pkg;

  localparam int REQ_A_WIDTH = 32;
  localparam int REQ_D_WIDTH = 32;
  localparam int REQ_W_WIDTH = REQ_A_WIDTH + REQ_D_WIDTH;

  typedef struct packed {
    logic                   we;
    logic [REQ_A_WIDTH-1:0] addr;
    logic [REQ_D_WIDTH-1:0] wdata;
  } cache_req_t;

  // Reads carry their address in the low bits; writes pack {addr, wdata}.
  function automatic cache_req_t unpack_req(input logic [REQ_W_WIDTH-1:0] data,
                                            input logic                   rw);
    cache_req_t r;
    r.we = rw;
    if (rw) begin
      r.addr  = data[REQ_W_WIDTH-1:REQ_D_WIDTH];
      r.wdata = data[REQ_D_WIDTH-1:0];
    end else begin
      r.addr  = data[REQ_A_WIDTH-1:0];
      r.wdata = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; pointers carry an extra
// wrap bit so full and empty are distinguished without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[PW-1:0]];
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                    (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign count    = wr_ptr - rd_ptr;

endmodule

// File: rtl/cache_req_queue.sv
// Buffers the arbiter's read/write stream and presents it as cache commands.
// Optional CACHE_REQ_QUEUE_STATS_EN adds push counters and an overflow flag.
module cache_req_queue
  import cache_req_pkg::*;
#(
  parameter int W_WIDTH = 64,
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32,
  parameter int DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_WIDTH-1:0]     in_data,
  input  logic                   in_valid,
  input  logic                   in_rw,
  output logic                   in_ready,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic                   req_we,
  output logic [A_WIDTH-1:0]     req_addr,
  output logic [D_WIDTH-1:0]     req_wdata,
  output logic [$clog2(DEPTH):0] count
`ifdef CACHE_REQ_QUEUE_STATS_EN
  ,
  output logic [15:0]            rd_cnt,
  output logic [15:0]            wr_cnt,
  output logic                   ovf_seen
`endif
);

  cache_req_t push_req;
  cache_req_t head_req;
  logic       full;
  logic       empty;
  logic       push;
  logic       pop;

  assign push_req = unpack_req(in_data, in_rw);

  // Handshakes depend only on registered occupancy, never on req_ready.
  assign in_ready  = !full;
  assign req_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = req_valid && req_ready;

  sync_fifo #(
    .WIDTH ($bits(cache_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_req),
    .pop       (pop),
    .pop_data  (head_req),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Storage is never reset, so an empty queue presents zeros instead of stale data.
  assign req_we    = req_valid && head_req.we;
  assign req_addr  = req_valid ? head_req.addr  : '0;
  assign req_wdata = req_valid ? head_req.wdata : '0;

`ifdef CACHE_REQ_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt   <= '0;
      wr_cnt   <= '0;
      ovf_seen <= 1'b0;
    end else begin
      if (push &&  in_rw && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 1'b1;
      if (push && !in_rw && (rd_cnt != 16'hFFFF)) rd_cnt <= rd_cnt + 1'b1;
      if (in_valid && !in_ready) ovf_seen <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/cache_req_queue.md
Name: cache_req_queue

Overview:
Downstream consumer of the read/write round-robin arbiter. Accepts the arbiter's registered output stream (64-bit data plus a read/write tag) and buffers it in a small FIFO. Unpacks each entry into a cache command (write-enable, address, write data) and presents it to the cache controller over a valid/ready handshake. Its ready output drives the arbiter's out_ready.

Parameters:
- W_WIDTH, 64, width of the incoming arbitrated data word.
- A_WIDTH, 32, cache address width.
- D_WIDTH, 32, cache write-data width; W_WIDTH must equal A_WIDTH + D_WIDTH.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- in_data  in  W_WIDTH  arbitrated word from the arbiter.
- in_valid  in  1  in_data is valid.
- in_rw  in  1  0 = read request, 1 = write request (the arbiter's read_or_write).
- in_ready  out  1  queue can accept; drives the arbiter's out_ready.
- req_valid  out  1  cache command is valid.
- req_ready  in  1  cache controller accepts the command.
- req_we  out  1  1 = write command.
- req_addr  out  A_WIDTH  command address.
- req_wdata  out  D_WIDTH  write data; 0 for reads.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Interface: single clock clk. rst is synchronous and active-high.
- Reset: on clk edge with rst=1, the FIFO empties and pointers clear. Outputs after reset: count=0, req_valid=0, req_we=0, req_addr=0, req_wdata=0, in_ready=1. A reset mid-operation discards all queued entries with no partial pop.
- Push: occurs when in_valid && in_ready at a clk edge.
- Push unpacking:
  - Write (in_rw=1): addr = in_data[W_WIDTH-1:D_WIDTH], wdata = in_data[D_WIDTH-1:0].
  - Read (in_rw=0): addr = in_data[A_WIDTH-1:0], wdata = 0. The upper bits are zero-extended upstream and are ignored here.
- Stored entry: {we, addr, wdata}.
- Pop: occurs when req_valid && req_ready.
- Output timing: first-word-fall-through. The head entry drives req_* combinationally from storage. req_valid = (count != 0).
- Latency: a push into an empty queue is visible on req_valid in the next cycle. There is no same-cycle bypass.
- in_ready = (count != DEPTH). It is combinational from registered state only, so there is no combinational path from req_ready.
- Simultaneous push and pop:
  - When 0 < count < DEPTH, count is unchanged and both pointers advance.
  - When full, in_ready=0, so only the pop occurs. in_ready rises in the following cycle.
  - When empty, only the push occurs.
- Pointers: wrap modulo DEPTH and carry an extra wrap bit for the full/empty distinction.
- Ordering: strict FIFO. Read/write order is preserved exactly as granted by the arbiter.
- Protocol: req_* must hold stable while req_valid=1 && req_ready=0.
- In-flight data: in_valid while in_ready=0 is not consumed. The arbiter is responsible for holding the data.

Optional Feature:
- Macro: CACHE_REQ_QUEUE_STATS_EN.
- When defined:
  - Adds outputs rd_cnt [15:0] and wr_cnt [15:0]. They count accepted pushes by type, saturate at 16'hFFFF, and clear on rst.
  - Adds output ovf_seen, a sticky flag set when in_valid=1 while in_ready=0.
- When undefined: these ports and registers do not exist, and core behaviour is identical.

Decomposition:
- Package cache_req_pkg holds:
  - Typedef cache_req_t, a packed struct {logic we; logic [A_WIDTH-1:0] addr; logic [D_WIDTH-1:0] wdata}.
  - Default width constants REQ_A_WIDTH=32 and REQ_D_WIDTH=32.
  - A function unpack_req(data, rw) returning cache_req_t.
- Sub-module sync_fifo: a generic FIFO parameterised by WIDTH and DEPTH with push/pop/full/empty/count. cache_req_queue instantiates it with WIDTH = $bits(cache_req_t) and adds the unpacking logic and the optional stats.

Test Plan:
- Reset: hold rst=1 for 2 cycles, then release. Expect count=0, req_valid=0, in_ready=1. Assert rst with 3 entries queued; next cycle expect count=0 and req_valid=0.
- Write unpack: push in_data=64'hDEAD_BEEF_1234_5678 with in_rw=1, req_ready=1. Next cycle expect req_valid=1, req_we=1, req_addr=32'hDEADBEEF, req_wdata=32'h12345678.
- Read unpack: push in_data=64'h0000_0000_0000_0040 with in_rw=0. Expect req_we=0, req_addr=32'h40, req_wdata=0.
- Full: with req_ready=0, push 4 entries. Expect count=4 and in_ready=0, and a 5th in_valid is not accepted. Pulse req_ready for 1 cycle; next cycle expect count=3 and in_ready=1.
- Order and simultaneous events: alternate R,W,R,W pushes while req_ready toggles 1,0,1,0. Expect output order R,W,R,W with exact data, and count stable on push+pop cycles.
- Stats, with CACHE_REQ_QUEUE_STATS_EN defined: push 3 reads and 2 writes. Expect rd_cnt=3 and wr_cnt=2. Drive in_valid=1 while the queue is full; expect ovf_seen=1 until rst.
